// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_if
//
// Purpose: request/result channel bundle between the instruction-issue logic
// (master) and the ALU operation sequencer (slave).
//
// Parameters:
//   WIDTH       operand width in bits
//
// Signals:
//   req_valid   master -> slave  request present
//   req_ready   slave  -> master sequencer can accept a request
//   req_op      master -> slave  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   req_a       master -> slave  operand A (dividend for DIV)
//   req_b       master -> slave  operand B (divisor for DIV)
//   res_valid   slave  -> master result present
//   res_ready   master -> slave  consumer takes the result
//   res_hi      slave  -> master MUL upper half / DIV remainder / 0
//   res_lo      slave  -> master sum, difference, MUL low half, DIV quotient
//   flag_carry  slave  -> master ADD carry-out / SUB borrow
//   flag_zero   slave  -> master {res_hi,res_lo} == 0
//   flag_dz     slave  -> master DIV by zero (or DIV unsupported)
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             flag_carry;
  logic             flag_zero;
  logic             flag_dz;

  modport master (
    output req_valid, req_op, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_hi, res_lo, flag_carry, flag_zero, flag_dz
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, res_ready,
    output req_ready, res_valid, res_hi, res_lo, flag_carry, flag_zero, flag_dz
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose: multi-cycle unsigned ALU operation sequencer. Accepts one request
// at a time; ADD/SUB finish in one cycle, MUL (shift-add) and DIV (restoring)
// iterate WIDTH times. A single WIDTH+1 bit adder is time-shared by all
// operations. Results and flags are registered and presented on a valid/ready
// result channel.
//
// Ports:
//   clk    input  rising-edge clock
//   rst_n  input  asynchronous active-low reset
//   bus    alu_op_sequencer_if.slave  request/result channels and flags
//
// Configuration macro:
//   ALU_SEQ_DIV_EN  defined   -> restoring divider present
//                   undefined -> opcode 11 completes in one cycle with
//                                res_hi=0, res_lo=0, flag_dz=1, flag_zero=1
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [1:0]      OP_ADD   = 2'b00;
  localparam logic [1:0]      OP_SUB   = 2'b01;
  localparam logic [1:0]      OP_MUL   = 2'b10;
  localparam logic [1:0]      OP_DIV   = 2'b11;
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Control and working registers
  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opb_q;      // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_hi_q;   // upper accumulator (MUL) or remainder (DIV)
  logic [WIDTH-1:0] acc_lo_q;   // multiplier (MUL) or dividend/quotient (DIV)
  logic [CW-1:0]    cnt_q;

  // Registered outputs
  logic             req_ready_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [WIDTH-1:0] res_lo_q;
  logic             flag_carry_q;
  logic             flag_zero_q;
  logic             flag_dz_q;

  // Shared adder and per-iteration next values
  logic [WIDTH-1:0] add_x_s;
  logic [WIDTH-1:0] add_y_s;
  logic             add_cin_s;
  logic [WIDTH:0]   add_sum_s;
  logic [WIDTH-1:0] step_hi_d;
  logic [WIDTH-1:0] step_lo_d;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] rem_sh_s;
  logic             no_borrow_s;

  // Remainder after the left shift of {rem,quot}; its dropped MSB is handled
  // separately so the trial subtract only needs WIDTH+1 bits.
  assign rem_sh_s = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
`endif

  // The one adder every operation shares; SUB and DIV feed ~B with carry-in 1.
  assign add_sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_cin_s};

  // Adder operand selection by state and operation.
  always_comb begin
    add_x_s   = ZERO_W;
    add_y_s   = ZERO_W;
    add_cin_s = 1'b0;
    case (state_q)
      IDLE: begin
        add_x_s = bus.req_a;
        if (bus.req_op == OP_SUB) begin
          add_y_s   = ~bus.req_b;
          add_cin_s = 1'b1;
        end else begin
          add_y_s   = bus.req_b;
          add_cin_s = 1'b0;
        end
      end
      EXEC: begin
        case (op_q)
          OP_MUL: begin
            add_x_s = acc_hi_q;
            if (acc_lo_q[0]) begin
              add_y_s = opb_q;
            end else begin
              add_y_s = ZERO_W;
            end
          end
`ifdef ALU_SEQ_DIV_EN
          OP_DIV: begin
            add_x_s   = rem_sh_s;
            add_y_s   = ~opb_q;
            add_cin_s = 1'b1;
          end
`endif
          default: begin
            add_x_s   = ZERO_W;
            add_y_s   = ZERO_W;
            add_cin_s = 1'b0;
          end
        endcase
      end
      default: begin
        add_x_s   = ZERO_W;
        add_y_s   = ZERO_W;
        add_cin_s = 1'b0;
      end
    endcase
  end

  // Next accumulator values for one MUL or DIV iteration.
  always_comb begin
    step_hi_d = acc_hi_q;
    step_lo_d = acc_lo_q;
`ifdef ALU_SEQ_DIV_EN
    no_borrow_s = 1'b0;
`endif
    case (op_q)
      OP_MUL: begin
        // {carry,hi,lo} >> 1 after the conditional add
        step_hi_d = add_sum_s[WIDTH:1];
        step_lo_d = {add_sum_s[0], acc_lo_q[WIDTH-1:1]};
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        // A set bit shifted out of rem means the shifted value already
        // exceeds any WIDTH-bit divisor.
        no_borrow_s = acc_hi_q[WIDTH-1] | add_sum_s[WIDTH];
        if (no_borrow_s) begin
          step_hi_d = add_sum_s[WIDTH-1:0];
        end else begin
          step_hi_d = rem_sh_s;
        end
        step_lo_d = {acc_lo_q[WIDTH-2:0], no_borrow_s};
      end
`endif
      default: begin
        step_hi_d = acc_hi_q;
        step_lo_d = acc_lo_q;
      end
    endcase
  end

  // Sequencer FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= OP_ADD;
      opb_q        <= ZERO_W;
      acc_hi_q     <= ZERO_W;
      acc_lo_q     <= ZERO_W;
      cnt_q        <= CNT_ZERO;
      req_ready_q  <= 1'b1;
      res_valid_q  <= 1'b0;
      res_hi_q     <= ZERO_W;
      res_lo_q     <= ZERO_W;
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
      flag_dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            opb_q       <= bus.req_b;
            cnt_q       <= CNT_LOAD;
            acc_hi_q    <= ZERO_W;
            acc_lo_q    <= bus.req_a;
            req_ready_q <= 1'b0;
            case (bus.req_op)
              OP_ADD, OP_SUB: begin
                state_q      <= DONE;
                res_valid_q  <= 1'b1;
                res_hi_q     <= ZERO_W;
                res_lo_q     <= add_sum_s[WIDTH-1:0];
                // SUB carry-out 0 means A < B
                flag_carry_q <= (bus.req_op == OP_ADD) ? add_sum_s[WIDTH] : ~add_sum_s[WIDTH];
                flag_zero_q  <= (add_sum_s[WIDTH-1:0] == ZERO_W);
                flag_dz_q    <= 1'b0;
              end
              OP_MUL: begin
                state_q <= EXEC;
              end
              OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                if (bus.req_b == ZERO_W) begin
                  state_q      <= DONE;
                  res_valid_q  <= 1'b1;
                  res_hi_q     <= bus.req_a;
                  res_lo_q     <= ONES_W;
                  flag_carry_q <= 1'b0;
                  flag_zero_q  <= 1'b0;
                  flag_dz_q    <= 1'b1;
                end else begin
                  state_q <= EXEC;
                end
`else
                state_q      <= DONE;
                res_valid_q  <= 1'b1;
                res_hi_q     <= ZERO_W;
                res_lo_q     <= ZERO_W;
                flag_carry_q <= 1'b0;
                flag_zero_q  <= 1'b1;
                flag_dz_q    <= 1'b1;
`endif
              end
              default: begin
                state_q <= IDLE;
              end
            endcase
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          if (cnt_q == CNT_ZERO) begin
            state_q      <= DONE;
            res_valid_q  <= 1'b1;
            res_hi_q     <= step_hi_d;
            res_lo_q     <= step_lo_d;
            flag_carry_q <= 1'b0;
            flag_zero_q  <= ({step_hi_d, step_lo_d} == {ZERO_W, ZERO_W});
            flag_dz_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_hi     = res_hi_q;
  assign bus.res_lo     = res_lo_q;
  assign bus.flag_carry = flag_carry_q;
  assign bus.flag_zero  = flag_zero_q;
  assign bus.flag_dz    = flag_dz_q;

endmodule
